// File: rtl/tensorflowe_dot_engine.sv
// tensorflowe_dot_engine
//
// Purpose:
//   Holds a DEPTH-entry signed weight buffer and computes a DEPTH-length
//   signed dot product against a streamed activation vector. The result can
//   optionally be saturated per accumulation step and clamped by ReLU. It is
//   then serialised one DATA_W-wide word per Ena_out strobe, least-significant
//   word first.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (also zeroes the weight buffer)
//   Datos_in     weight (with Ena_write) or activation (with enable_accu)
//   Ena_write    write Datos_in to weight[wptr]           (IDLE only)
//   enable_accu  acc += Datos_in * weight[aptr]           (IDLE or ACCUM)
//   Ena_read     Datos_out <= weight[rptr]                (IDLE only)
//   Ena_out      Datos_out <= next result word            (RESULT only)
//   clear        synchronous soft clear; weights and Datos_out are kept
//   sat_en       1 = saturate on overflow, 0 = two's-complement wrap
//   relu_en      1 = negative result reads out as zero
//   Datos_out    registered output word
//   out_valid    one-cycle pulse: Datos_out was loaded at the last edge
//   busy         state is ACCUM
//   done         one-cycle pulse after the last activation of a vector
//   state_dbg    current FSM state (IDLE=0, ACCUM=1, RESULT=2)
//
// Handshake: every strobe is a single-cycle request with no backpressure.
// Each cycle, only the highest-priority strobe that is legal in the current
// state acts (clear > Ena_write > enable_accu > Ena_read > Ena_out). The
// other strobes are dropped, not queued. out_valid is high for exactly the
// cycle after the edge that loaded Datos_out.

module tensorflowe_dot_engine #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int ACC_W     = 24,
  parameter int OUT_WORDS = ACC_W / DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Datos_in,
  input  logic              Ena_write,
  input  logic              enable_accu,
  input  logic              Ena_read,
  input  logic              Ena_out,
  input  logic              clear,
  input  logic              sat_en,
  input  logic              relu_en,
  output logic [DATA_W-1:0] Datos_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OPTR_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [OPTR_W-1:0] OPTR_LAST = OPTR_W'(OUT_WORDS - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] weight [DEPTH];
  logic [PTR_W-1:0]         wptr, aptr, rptr;
  logic [OPTR_W-1:0]        optr;
  logic signed [ACC_W-1:0]  acc;

  // Decoded single action for this cycle.
  logic do_clear, do_write, do_accu, do_read, do_out;

  // Accumulate datapath.
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  addend, base, sum, acc_step;
  logic                     ovf;

  // Output datapath.
  logic signed [ACC_W-1:0]  res;
  logic [DATA_W-1:0]        out_word;

  // Legal-strobe priority decode.
  always_comb begin
    do_clear = clear;
    do_write = !do_clear && Ena_write && (state == IDLE);
    do_accu  = !do_clear && !do_write && enable_accu && (state != RESULT);
    do_read  = !do_clear && !do_write && !do_accu && Ena_read && (state == IDLE);
    do_out   = !do_clear && !do_write && !do_accu && !do_read && Ena_out &&
               (state == RESULT);
  end

  // One multiply-accumulate step. A new vector starting from IDLE always
  // uses zero as its base, so a stale acc can never leak into a fresh result.
  always_comb begin
    product = PROD_W'($signed(Datos_in)) * PROD_W'(weight[aptr]);
    addend  = ACC_W'(product);
    base    = (state == IDLE) ? '0 : acc;
    sum     = base + addend;
    // Overflow occurs only when both addends share a sign and the sum flips it.
    ovf     = (base[ACC_W-1] == addend[ACC_W-1]) &&
              (sum[ACC_W-1] != base[ACC_W-1]);
    if (ovf && sat_en) begin
      acc_step = addend[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_step = sum;
    end
  end

  // ReLU is applied at read-out time, so each word sees the current relu_en.
  always_comb begin
    res      = (relu_en && acc[ACC_W-1]) ? '0 : acc;
    out_word = res[optr*DATA_W +: DATA_W];
  end

  // FSM next state.
  always_comb begin
    state_next = state;
    if (do_clear) begin
      state_next = IDLE;
    end else if (do_accu) begin
      state_next = (aptr == PTR_LAST) ? RESULT : ACCUM;
    end else if (do_out && (optr == OPTR_LAST)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        weight[i] <= '0;
      end
      wptr      <= '0;
      aptr      <= '0;
      rptr      <= '0;
      optr      <= '0;
      acc       <= '0;
      Datos_out <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (do_clear) begin
        wptr <= '0;
        aptr <= '0;
        rptr <= '0;
        optr <= '0;
        acc  <= '0;
      end else if (do_write) begin
        weight[wptr] <= Datos_in;
        wptr         <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      end else if (do_accu) begin
        acc <= acc_step;
        if (aptr == PTR_LAST) begin
          aptr <= '0;
          done <= 1'b1;
        end else begin
          aptr <= aptr + 1'b1;
        end
      end else if (do_read) begin
        Datos_out <= weight[rptr];
        out_valid <= 1'b1;
        rptr      <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      end else if (do_out) begin
        Datos_out <= out_word;
        out_valid <= 1'b1;
        if (optr == OPTR_LAST) begin
          optr <= '0;
          acc  <= '0;
        end else begin
          optr <= optr + 1'b1;
        end
      end
    end
  end

  assign busy      = (state == ACCUM);
  assign state_dbg = state;

endmodule
